// File: rtl/div_pkg.sv
// Shared constants for the HI/LO arithmetic units: default widths and the
// divider state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/div_if.sv
// Divider handshake and operand/result bundle between control unit and divider.
interface div_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);
  logic [WIDTH-1:0] entradaA;
  logic [WIDTH-1:0] entradaB;
  logic             divInit;
  logic             divStop;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output entradaA, entradaB, divInit,
    input  divStop, divZero, hi, lo
  );

  modport slave (
    input  entradaA, entradaB, divInit,
    output divStop, divZero, hi, lo
  );
endinterface

// File: rtl/div_sign_unit.sv
// Conditional two's-complement negate: magnitude of a signed operand, or
// sign restoration of an unsigned result.
module div_sign_unit #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/div.sv
// Iterative signed restoring divider: lo = quotient (toward zero),
// hi = remainder (sign of dividend), one quotient bit per cycle.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_q_q, sign_q_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH+1:0] shifted, trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter, b_is_zero;
  logic             div_stop, div_zero;

  div_sign_unit #(.WIDTH(WIDTH)) u_abs_a (
    .value_i(bus.entradaA), .neg_i(bus.entradaA[WIDTH-1]), .result_o(a_abs));
  div_sign_unit #(.WIDTH(WIDTH)) u_abs_b (
    .value_i(bus.entradaB), .neg_i(bus.entradaB[WIDTH-1]), .result_o(b_abs));
  div_sign_unit #(.WIDTH(WIDTH)) u_fix_q (
    .value_i(q_next), .neg_i(sign_q_q), .result_o(q_fix));
  div_sign_unit #(.WIDTH(WIDTH)) u_fix_r (
    .value_i(r_next[WIDTH-1:0]), .neg_i(sign_a_q), .result_o(r_fix));

  assign b_is_zero = (bus.entradaB == '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step; the extra top bit keeps the trial subtract's sign
  // unambiguous even for a 0x80000000 divisor magnitude.
  always_comb begin
    shifted = {r_q, q_q[WIDTH-1]};
    trial   = shifted - {2'b00, b_q};
    if (!trial[WIDTH+1]) begin
      r_next = trial[WIDTH:0];
      q_next = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted[WIDTH:0];
      q_next = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_a_q <= sign_a_d;
      sign_q_q <= sign_q_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.divInit) state_d = b_is_zero ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (!bus.divInit)  state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!bus.divInit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_a_d = sign_a_q;
    sign_q_d = sign_q_q;
    zero_d   = zero_q;
    if (state_q == ST_IDLE && bus.divInit) begin
      q_d      = a_abs;
      b_d      = b_abs;
      r_d      = '0;
      cnt_d    = '0;
      sign_a_d = bus.entradaA[WIDTH-1];
      sign_q_d = bus.entradaA[WIDTH-1] ^ bus.entradaB[WIDTH-1];
      zero_d   = b_is_zero;
    end else if (state_q == ST_RUN && bus.divInit) begin
      r_d   = r_next;
      q_d   = q_next;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        hi_d = r_fix;
        lo_d = q_fix;
      end
    end else if (state_q == ST_DONE) begin
      zero_d = 1'b0;
    end
  end

  always_comb begin
    div_stop = (state_q == ST_DONE);
    div_zero = (state_q == ST_DONE) && zero_q;
  end

  assign bus.divStop = div_stop;
  assign bus.divZero = div_zero;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative signed divider.
module tb_div;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset;
  div_if bus();

  div dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stop_cyc;
  int pulses;
  logic zero_seen;

  // Start an operation and watch divStop; cycle 1 is the edge that samples divInit.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold_extra);
    @(negedge clk);
    bus.entradaA = a;
    bus.entradaB = b;
    bus.divInit  = 1'b1;
    stop_cyc  = -1;
    pulses    = 0;
    zero_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.divStop) begin
        pulses++;
        if (stop_cyc < 0) begin
          stop_cyc  = c;
          zero_seen = bus.divZero;
        end
      end
      if (stop_cyc >= 0 && c >= stop_cyc + hold_extra) break;
    end
    @(negedge clk);
    bus.divInit = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.divInit  = 1'b0;
    bus.entradaA = '0;
    bus.entradaB = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.hi, bus.lo, bus.divStop, bus.divZero} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hi=%h lo=%h stop=%b zero=%b, expected all zero",
               bus.hi, bus.lo, bus.divStop, bus.divZero);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] a_t[4], b_t[4], lo_t[4], hi_t[4];
    a_t  = '{32'd7,        32'hFFFFFFF9, 32'd7,        32'hFFFFFFF9};
    b_t  = '{32'd2,        32'd2,        32'hFFFFFFFE, 32'hFFFFFFFE};
    lo_t = '{32'd3,        32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3};
    hi_t = '{32'd1,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      do_op(a_t[i], b_t[i], 2);
      n_checks++;
      if (bus.lo !== lo_t[i]) begin
        n_fail++;
        $display("FAIL signed[%0d] lo: got %h expected %h", i, bus.lo, lo_t[i]);
      end
      n_checks++;
      if (bus.hi !== hi_t[i]) begin
        n_fail++;
        $display("FAIL signed[%0d] hi: got %h expected %h", i, bus.hi, hi_t[i]);
      end
      n_checks++;
      if (stop_cyc !== 33) begin
        n_fail++;
        $display("FAIL signed[%0d] latency: got %0d expected 33", i, stop_cyc);
      end
      n_checks++;
      if (pulses !== 1 || zero_seen !== 1'b0) begin
        n_fail++;
        $display("FAIL signed[%0d] pulse: got pulses=%0d zero=%b expected 1 and 0",
                 i, pulses, zero_seen);
      end
    end
  endtask

  task automatic test_overflow();
    do_op(32'h80000000, 32'hFFFFFFFF, 2);
    n_checks++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin
      n_fail++;
      $display("FAIL overflow: got lo=%h hi=%h expected lo=80000000 hi=00000000", bus.lo, bus.hi);
    end
    do_op(32'h12345678, 32'h80000000, 2);
    n_checks++;
    if (bus.lo !== 32'h0 || bus.hi !== 32'h12345678) begin
      n_fail++;
      $display("FAIL min_divisor: got lo=%h hi=%h expected lo=00000000 hi=12345678", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero();
    do_op(32'h12345678, 32'd1, 2);
    do_op(32'd5, 32'd0, 2);
    n_checks++;
    if (stop_cyc !== 1 || zero_seen !== 1'b1 || pulses !== 1) begin
      n_fail++;
      $display("FAIL div_zero_flag: got cyc=%0d zero=%b pulses=%0d expected 1 1 1",
               stop_cyc, zero_seen, pulses);
    end
    n_checks++;
    if (bus.lo !== 32'h12345678 || bus.hi !== 32'h0) begin
      n_fail++;
      $display("FAIL div_zero_keep: got lo=%h hi=%h expected lo=12345678 hi=00000000", bus.lo, bus.hi);
    end
    n_checks++;
    if (bus.divZero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_clear: got %b expected 0", bus.divZero);
    end
  endtask

  task automatic test_hold();
    do_op(32'd100, 32'd7, 10);
    n_checks++;
    if (pulses !== 1 || stop_cyc !== 33) begin
      n_fail++;
      $display("FAIL hold_single_pulse: got pulses=%0d cyc=%0d expected 1 and 33", pulses, stop_cyc);
    end
    n_checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      n_fail++;
      $display("FAIL hold_result: got lo=%h hi=%h expected lo=0000000e hi=00000002", bus.lo, bus.hi);
    end
  endtask

  task automatic test_async_reset();
    do_op(32'd7, 32'd2, 2);
    @(negedge clk);
    bus.entradaA = 32'd1000;
    bus.entradaB = 32'd3;
    bus.divInit  = 1'b1;
    repeat (16) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.hi, bus.lo, bus.divStop, bus.divZero} !== 66'd0) begin
      n_fail++;
      $display("FAIL async_reset: got hi=%h lo=%h stop=%b zero=%b expected all zero",
               bus.hi, bus.lo, bus.divStop, bus.divZero);
    end
    @(negedge clk);
    bus.divInit = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    do_op(32'd100, 32'd7, 2);
    n_checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || stop_cyc !== 33) begin
      n_fail++;
      $display("FAIL after_reset: got lo=%h hi=%h cyc=%0d expected 0000000e 00000002 33",
               bus.lo, bus.hi, stop_cyc);
    end
  endtask

  task automatic test_abort();
    int seen;
    do_op(32'hFFFFFFF9, 32'd2, 2);
    @(negedge clk);
    bus.entradaA = 32'd100;
    bus.entradaB = 32'd7;
    bus.divInit  = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.divInit = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.divStop) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_stop: got %0d pulses expected 0", seen);
    end
    n_checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL abort_keep: got lo=%h hi=%h expected lo=fffffffd hi=ffffffff", bus.lo, bus.hi);
    end
    do_op(32'd9, 32'd4, 2);
    n_checks++;
    if (bus.lo !== 32'd2 || bus.hi !== 32'd1 || stop_cyc !== 33) begin
      n_fail++;
      $display("FAIL after_abort: got lo=%h hi=%h cyc=%0d expected 00000002 00000001 33",
               bus.lo, bus.hi, stop_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_overflow();
    test_div_zero();
    test_hold();
    test_async_reset();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
